// File: rtl/fmap_stream_tx_pkg.sv
// Shared constants and state types for the conv2 input feature-map transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fmap_stream_tx_pkg;

  // conv2 input map geometry: 13x13 binary pixels, 8 channels each
  localparam int IMG_W      = 13;
  localparam int IMG_H      = 13;
  localparam int CH         = 8;
  localparam int N          = IMG_W * IMG_H;
  localparam int CNT_W      = $clog2(N);
  // idle cycles between output frames so conv2 can flush its line buffers
  localparam int GAP_CYCLES = 2;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_GAP    = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fmap_stream_tx_if.sv
// Pixel write handshake plus the conv2-facing raster stream, bundled as one bus.
// Latency: n/a (wiring only).
// Backpressure: wr_ready throttles the source; the output stream has none.
// Ports: wr_valid/wr_ready/wr_pixel (source -> block), pix_out/out_valid/
//        out_first/out_last/frame_done (block -> conv2).
// Modports: master = pixel source and stream sink, slave = fmap_stream_tx.
interface fmap_stream_tx_if
  import fmap_stream_tx_pkg::*;
#(
  parameter int PIX_W = CH
);
  logic             wr_valid;
  logic             wr_ready;
  logic [PIX_W-1:0] wr_pixel;
  logic [PIX_W-1:0] pix_out;
  logic             out_valid;
  logic             out_first;
  logic             out_last;
  logic             frame_done;

  modport master (
    output wr_valid, wr_pixel,
    input  wr_ready, pix_out, out_valid, out_first, out_last, frame_done
  );

  modport slave (
    input  wr_valid, wr_pixel,
    output wr_ready, pix_out, out_valid, out_first, out_last, frame_done
  );
endinterface

// File: rtl/fmap_bank_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// Latency: 1 cycle from raddr/re to rdata.
// Backpressure: none; rdata returns to 0 on any cycle without a read.
// Ports: clk, rst (clears only the read register), we/waddr/wdata,
//        re/raddr/rdata.
module fmap_bank_ram #(
  parameter int AW    = 9,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zeroing the register on idle cycles keeps the downstream pixel bus at 0
  // whenever no frame pixel is being presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end
endmodule

// File: rtl/fmap_stream_tx.sv
// Ping-pong frame buffer: collects pool-1 pixels, replays whole frames to conv2.
// Latency: first out_valid 2 cycles after the final write of a frame (reader idle).
// Backpressure: wr_ready low while the write bank is FULL; output is never stalled.
// Ports: clk, rst (sync, active-high), bus (fmap_stream_tx_if.slave):
//        write handshake in, 169-cycle unbroken raster stream plus
//        out_first/out_last/frame_done markers out.
module fmap_stream_tx #(
  parameter int IMG_W      = fmap_stream_tx_pkg::IMG_W,
  parameter int IMG_H      = fmap_stream_tx_pkg::IMG_H,
  parameter int CH         = fmap_stream_tx_pkg::CH,
  parameter int GAP_CYCLES = fmap_stream_tx_pkg::GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  fmap_stream_tx_if.slave   bus
);
  import fmap_stream_tx_pkg::*;

  localparam int             NPIX     = IMG_W * IMG_H;
  localparam int             CW       = $clog2(NPIX);
  localparam logic [CW-1:0]  LAST_IDX = CW'(NPIX - 1);
  localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  bank_state_e   bank_st [2];
  logic          wsel;
  logic          rsel;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] rcnt;
  logic [GW-1:0] gcnt;
  rd_state_e     rd_st;
  logic          out_valid_q;
  logic          out_first_q;
  logic          out_last_q;
  logic          frame_done_q;

  logic          wr_acc;
  logic          rd_issue;

  // Ready depends only on state registers, never on wr_valid.
  assign bus.wr_ready = (bank_st[wsel] == BANK_FREE);
  assign wr_acc       = bus.wr_valid && bus.wr_ready;
  assign rd_issue     = (rd_st == RD_STREAM);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0]   <= BANK_FREE;
      bank_st[1]   <= BANK_FREE;
      wsel         <= 1'b0;
      rsel         <= 1'b0;
      wcnt         <= '0;
      rcnt         <= '0;
      gcnt         <= '0;
      rd_st        <= RD_IDLE;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // Writer and reader always own different banks, so their bank_st
      // updates below never collide on the same entry.
      if (wr_acc) begin
        if (wcnt == LAST_IDX) begin
          wcnt          <= '0;
          bank_st[wsel] <= BANK_FULL;
          wsel          <= ~wsel;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      // Markers are delayed one cycle to line up with the registered RAM read.
      out_valid_q  <= rd_issue;
      out_first_q  <= rd_issue && (rcnt == '0);
      out_last_q   <= rd_issue && (rcnt == LAST_IDX);
      frame_done_q <= out_last_q;

      case (rd_st)
        RD_IDLE: begin
          if (bank_st[rsel] == BANK_FULL) begin
            rd_st <= RD_STREAM;
            rcnt  <= '0;
          end
        end
        RD_STREAM: begin
          if (rcnt == LAST_IDX) begin
            // Bank is released as soon as its last word has been addressed,
            // so the writer can refill it from the next cycle.
            bank_st[rsel] <= BANK_FREE;
            rsel          <= ~rsel;
            gcnt          <= '0;
            rd_st         <= (GAP_CYCLES == 0) ? RD_IDLE : RD_GAP;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        RD_GAP: begin
          if (gcnt == GAP_LAST) begin
            rd_st <= RD_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: rd_st <= RD_IDLE;
      endcase
    end
  end

  // Single RAM; the top address bit selects the ping or pong bank.
  fmap_bank_ram #(
    .AW    (CW + 1),
    .WIDTH (CH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr ({wsel, wcnt}),
    .wdata (bus.wr_pixel),
    .re    (rd_issue),
    .raddr ({rsel, rcnt}),
    .rdata (bus.pix_out)
  );

  assign bus.out_valid  = out_valid_q;
  assign bus.out_first  = out_first_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_fmap_stream_tx.sv
// Randomized bench for fmap_stream_tx against a frame-level timing model.
// Latency: n/a (testbench).
// Backpressure: source honours the model's predicted wr_ready; blocked beats carry 0xFF.
module tb_fmap_stream_tx;
  import fmap_stream_tx_pkg::*;

  localparam int NP   = IMG_W * IMG_H;
  localparam int MAXF = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmap_stream_tx_if bus ();

  fmap_stream_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Reference model: list of completed frames with their predicted stream
  // start edge. A frame starts 2 edges after its last write, but no earlier
  // than NP + GAP_CYCLES + 1 edges after the previous frame started.
  logic [CH-1:0] m_frame [MAXF][NP];
  logic [CH-1:0] m_cur [NP];
  int            m_start [MAXF];
  int            m_nfr = 0;
  int            m_wcnt = 0;
  int            m_out_idx = -1;
  int            m_busy = 0;
  bit            m_wr_ready = 1'b1;
  bit            e_valid, e_first, e_last, e_done;
  logic [CH-1:0] e_pix;
  int            n_last_dut = 0;
  int            n_last_exp = 0;
  int            n_ff = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int last_done();
    return (m_nfr > 0) ? m_start[m_nfr-1] + NP : 0;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_nfr  = 0;
      m_wcnt = 0;
    end else if (bus.wr_valid && m_wr_ready) begin
      m_cur[m_wcnt] = bus.wr_pixel;
      m_wcnt++;
      if (m_wcnt == NP) begin
        m_wcnt = 0;
        if (m_nfr < MAXF) begin
          for (int j = 0; j < NP; j++) m_frame[m_nfr][j] = m_cur[j];
          m_start[m_nfr] = edge_n + 2;
          if (m_nfr > 0 && m_start[m_nfr-1] + NP + GAP_CYCLES + 1 > m_start[m_nfr])
            m_start[m_nfr] = m_start[m_nfr-1] + NP + GAP_CYCLES + 1;
          m_nfr++;
        end else begin
          chk_eq("model_overflow", 32'(m_nfr), 32'(MAXF - 1));
        end
      end
    end

    e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0; e_done = 1'b0;
    e_pix = '0; m_busy = 0; m_out_idx = -1;
    for (int i = 0; i < m_nfr; i++) begin
      if (edge_n >= m_start[i] && edge_n <= m_start[i] + NP - 1) begin
        e_valid   = 1'b1;
        m_out_idx = edge_n - m_start[i];
        e_pix     = m_frame[i][m_out_idx];
        e_first   = (m_out_idx == 0);
        e_last    = (m_out_idx == NP - 1);
      end
      if (edge_n == m_start[i] + NP) e_done = 1'b1;
      // a bank is released on the edge that presents its last pixel
      if (edge_n < m_start[i] + NP - 1) m_busy++;
    end
    m_wr_ready = (m_busy < 2);
    if (e_last) n_last_exp++;

    #1;
    chk_eq("out_valid",  32'(bus.out_valid),  32'(e_valid));
    chk_eq("pix_out",    32'(bus.pix_out),    32'(e_pix));
    chk_eq("out_first",  32'(bus.out_first),  32'(e_first));
    chk_eq("out_last",   32'(bus.out_last),   32'(e_last));
    chk_eq("frame_done", 32'(bus.frame_done), 32'(e_done));
    chk_eq("wr_ready",   32'(bus.wr_ready),   32'(m_wr_ready));
    if (bus.out_last) n_last_dut++;
    if (bus.out_valid && bus.pix_out == {CH{1'b1}}) n_ff++;
  end

  // pace: 0 = every cycle, 1 = every 3rd cycle, 2 = random
  task automatic write_pix(input int count, input bit rnd, input int pace);
    logic [CH-1:0] data [NP];
    int idx = 0;
    int guard = 0;
    int cyc = 0;
    bit want;
    for (int j = 0; j < count; j++)
      data[j] = rnd ? CH'($urandom_range(0, 254)) : CH'(j);
    while (idx < count && guard < 4000) begin
      @(negedge clk);
      case (pace)
        0:       want = 1'b1;
        1:       want = (cyc % 3 == 2);
        default: want = ($urandom_range(0, 3) != 0);
      endcase
      cyc++;
      guard++;
      bus.wr_valid = want;
      bus.wr_pixel = (want && m_wr_ready) ? data[idx] : {CH{1'b1}};
      if (want && m_wr_ready) idx++;
    end
    if (idx < count) chk_eq("wr_timeout", 32'(idx), 32'(count));
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.wr_pixel = '0;
  endtask

  task automatic drain();
    int guard = 0;
    while (edge_n <= last_done() + 2 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) chk_eq("drain_timeout", 32'(guard), 32'(0));
  endtask

  task automatic wait_idx(input int target);
    int guard = 0;
    while (m_out_idx != target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) chk_eq("wait_idx_timeout", 32'(m_out_idx), 32'(target));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_pixel = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // contiguous frame, pixel = index
    write_pix(NP, 1'b0, 0);
    go_idle();
    drain();

    // sparse writes, every 3rd cycle
    write_pix(NP, 1'b0, 1);
    go_idle();
    drain();

    // three frames back to back with wr_valid held; blocked beats carry 0xFF
    write_pix(NP, 1'b0, 0);
    write_pix(NP, 1'b1, 0);
    write_pix(NP, 1'b1, 0);
    go_idle();
    drain();

    // reset in the middle of a stream with a partial frame pending
    write_pix(NP, 1'b1, 0);
    write_pix(40, 1'b1, 0);
    go_idle();
    wait_idx(50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // fresh frame after reset, then randomly paced random frames
    write_pix(NP, 1'b0, 0);
    go_idle();
    drain();
    write_pix(NP, 1'b1, 2);
    write_pix(NP, 1'b1, 2);
    go_idle();
    drain();

    chk_eq("frames_out", 32'(n_last_dut), 32'(n_last_exp));
    chk_eq("no_ff_stored", 32'(n_ff), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
